data_mem_arbiter: RTL and testbench

Sits directly downstream of the per-thread load/store units and upstream of external data memory. Accepts NUM_CONSUMERS independent read/write requests, each held with a valid/ready handshake. Multiplexes those requests onto NUM_CHANNELS memory channels. Relays read data and completion back to the requesting unit, so many LSUs share a few memory ports.

---
 rtl/data_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares NUM_CHANNELS memory channels among NUM_CONSUMERS
// load/store units. Each channel runs a small FSM that grants one consumer,
// forwards its request to memory, and relays the completion back.
//
// Handshake: every request/completion pair is valid/ready. A requester holds
// valid (and its address/data) stable until it sees ready; the arbiter holds
// ready until it samples the requester's valid low, then frees the channel.
// On the memory side mem_*_valid/address/data stay stable from grant until
// mem_*_ready is sampled high.
module data_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int   ID_W  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic WR_EN = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_WAIT,
    ST_WRITE_WAIT,
    ST_READ_RELAY,
    ST_WRITE_RELAY
  } state_t;

  // Per-channel state and owner; state_q is the debug view of every FSM.
  state_t                    state_q [NUM_CHANNELS];
  state_t                    state_d [NUM_CHANNELS];
  logic   [ID_W-1:0]         id_q    [NUM_CHANNELS];
  logic   [ID_W-1:0]         id_d    [NUM_CHANNELS];
  logic   [NUM_CONSUMERS-1:0] claim_q, claim_d;

  // Next values of the registered outputs.
  logic [NUM_CONSUMERS-1:0]           rd_ready_d, wr_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_d;
  logic [NUM_CHANNELS-1:0]            mrv_d, mwv_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mra_d, mwa_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mwd_d;

  // Scratch for the in-order channel scan.
  logic [NUM_CONSUMERS-1:0] taken;
  logic                     found;
  logic [NUM_CONSUMERS-1:0] write_req;

  // A read-only build never sees a write request at all.
  assign write_req = WR_EN ? consumer_write_valid : '0;

  // Next-state logic: channels scanned in index order so a consumer granted to
  // a lower channel is hidden from higher channels in the same cycle.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    claim_d    = claim_q;
    taken      = claim_q;
    found      = 1'b0;
    rd_ready_d = consumer_read_ready;
    wr_ready_d = consumer_write_ready;
    rd_data_d  = consumer_read_data;
    mrv_d      = mem_read_valid;
    mra_d      = mem_read_address;
    mwv_d      = mem_write_valid;
    mwa_d      = mem_write_address;
    mwd_d      = mem_write_data;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      case (state_q[c])
        ST_IDLE: begin
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (!found && !taken[i] && (consumer_read_valid[i] || write_req[i])) begin
              found      = 1'b1;
              taken[i]   = 1'b1;
              claim_d[i] = 1'b1;
              id_d[c]    = ID_W'(i);
              // Read wins when both are pending; the write follows later.
              if (consumer_read_valid[i]) begin
                mrv_d[c] = 1'b1;
                mra_d[c*ADDR_BITS +: ADDR_BITS] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
                state_d[c] = ST_READ_WAIT;
              end else begin
                mwv_d[c] = 1'b1;
                mwa_d[c*ADDR_BITS +: ADDR_BITS] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
                mwd_d[c*DATA_BITS +: DATA_BITS] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
                state_d[c] = ST_WRITE_WAIT;
              end
            end
          end
        end
        ST_READ_WAIT: begin
          if (mem_read_ready[c]) begin
            mrv_d[c] = 1'b0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
              if (id_q[c] == ID_W'(i)) begin
                rd_data_d[i*DATA_BITS +: DATA_BITS] = mem_read_data[c*DATA_BITS +: DATA_BITS];
                rd_ready_d[i] = 1'b1;
              end
            end
            state_d[c] = ST_READ_RELAY;
          end
        end
        ST_WRITE_WAIT: begin
          if (mem_write_ready[c]) begin
            mwv_d[c] = 1'b0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
              if (id_q[c] == ID_W'(i)) wr_ready_d[i] = 1'b1;
            end
            state_d[c] = ST_WRITE_RELAY;
          end
        end
        ST_READ_RELAY: begin
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (id_q[c] == ID_W'(i) && !consumer_read_valid[i]) begin
              rd_ready_d[i] = 1'b0;
              claim_d[i]    = 1'b0;
              state_d[c]    = ST_IDLE;
            end
          end
        end
        ST_WRITE_RELAY: begin
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (id_q[c] == ID_W'(i) && !consumer_write_valid[i]) begin
              wr_ready_d[i] = 1'b0;
              claim_d[i]    = 1'b0;
              state_d[c]    = ST_IDLE;
            end
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        id_q[c]    <= '0;
      end
      claim_q              <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      state_q              <= state_d;
      id_q                 <= id_d;
      claim_q              <= claim_d;
      consumer_read_ready  <= rd_ready_d;
      consumer_write_ready <= wr_ready_d;
      consumer_read_data   <= rd_data_d;
      mem_read_valid       <= mrv_d;
      mem_read_address     <= mra_d;
      mem_write_valid      <= mwv_d;
      mem_write_address    <= mwa_d;
      mem_write_data       <= mwd_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: dut_a (1 channel, writes on) and dut_b
// (2 channels, read-only) each with a fixed-latency memory responder.
module tb_data_mem_arbiter;
  localparam int NC     = 4;
  localparam int AB     = 8;
  localparam int DB     = 8;
  localparam int LAT    = 2;
  localparam int BUDGET = 60;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- dut_a signals ----------------
  logic [NC-1:0]    a_rd_valid, a_rd_ready, a_wr_valid, a_wr_ready;
  logic [NC*AB-1:0] a_rd_addr, a_wr_addr;
  logic [NC*DB-1:0] a_rd_data, a_wr_data;
  logic [0:0]       a_mrv, a_mrr, a_mwv, a_mwr;
  logic [AB-1:0]    a_mra, a_mwa;
  logic [DB-1:0]    a_mrd, a_mwd;

  // ---------------- dut_b signals ----------------
  logic [NC-1:0]    b_rd_valid, b_rd_ready, b_wr_valid, b_wr_ready;
  logic [NC*AB-1:0] b_rd_addr, b_wr_addr;
  logic [NC*DB-1:0] b_rd_data, b_wr_data;
  logic [1:0]       b_mrv, b_mrr, b_mwv, b_mwr;
  logic [2*AB-1:0]  b_mra, b_mwa;
  logic [2*DB-1:0]  b_mrd, b_mwd;

  data_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_BITS(AB),
                     .DATA_BITS(DB), .WRITE_ENABLE(1)) dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_rd_valid), .consumer_read_address(a_rd_addr),
    .consumer_read_ready(a_rd_ready), .consumer_read_data(a_rd_data),
    .consumer_write_valid(a_wr_valid), .consumer_write_address(a_wr_addr),
    .consumer_write_data(a_wr_data), .consumer_write_ready(a_wr_ready),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  data_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(2), .ADDR_BITS(AB),
                     .DATA_BITS(DB), .WRITE_ENABLE(0)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_rd_valid), .consumer_read_address(b_rd_addr),
    .consumer_read_ready(b_rd_ready), .consumer_read_data(b_rd_data),
    .consumer_write_valid(b_wr_valid), .consumer_write_address(b_wr_addr),
    .consumer_write_data(b_wr_data), .consumer_write_ready(b_wr_ready),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;
  logic [9:0] exp_q[$];   // {consumer id, read data} in expected completion order
  int reuse_err = 0;
  int overlap_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- memory models ----------------
  logic [DB-1:0] mem_a [256];
  bit mem_auto = 1'b1;
  bit manual_rd_ready = 1'b0;

  initial begin
    int rd_cnt, wr_cnt;
    rd_cnt = 0; wr_cnt = 0;
    a_mrr = '0; a_mwr = '0; a_mrd = '0;
    forever begin
      @(negedge clk);
      a_mrr = '0;
      a_mwr = '0;
      if (!mem_auto) begin
        a_mrr[0] = manual_rd_ready;
        rd_cnt = 0; wr_cnt = 0;
      end else begin
        if (a_mrv[0]) begin
          rd_cnt++;
          if (rd_cnt == LAT) begin a_mrr = 1'b1; a_mrd = mem_a[a_mra]; rd_cnt = 0; end
        end else rd_cnt = 0;
        if (a_mwv[0]) begin
          wr_cnt++;
          if (wr_cnt == LAT) begin a_mwr = 1'b1; mem_a[a_mwa] = a_mwd; wr_cnt = 0; end
        end else wr_cnt = 0;
      end
    end
  end

  // dut_b memory returns address ^ 0x5A on each channel.
  initial begin
    int cnt [2];
    cnt[0] = 0; cnt[1] = 0;
    b_mrr = '0; b_mwr = '0; b_mrd = '0;
    forever begin
      @(negedge clk);
      b_mrr = '0;
      for (int c = 0; c < 2; c++) begin
        if (b_mrv[c]) begin
          cnt[c]++;
          if (cnt[c] == LAT) begin
            b_mrr[c] = 1'b1;
            b_mrd[c*DB +: DB] = b_mra[c*AB +: AB] ^ 8'h5A;
            cnt[c] = 0;
          end
        end else cnt[c] = 0;
      end
    end
  end

  // ---------------- monitor on dut_a ----------------
  initial begin
    logic [NC-1:0] prev;
    logic [9:0] e;
    prev = '0;
    forever begin
      @(negedge clk);
      if ((a_mrv[0] || a_mwv[0]) && ((|a_rd_ready) || (|a_wr_ready))) reuse_err++;
      if ($countones(a_rd_ready | a_wr_ready) > 1) overlap_err++;
      for (int i = 0; i < NC; i++) begin
        if (a_rd_ready[i] && !prev[i]) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL sb_unexpected: consumer %0d ready with data 0x%0h, none expected", i, a_rd_data[i*DB +: DB]);
          end else begin
            e = exp_q.pop_front();
            check("sb_read", {2'(i), a_rd_data[i*DB +: DB]}, e);
          end
        end
      end
      prev = a_rd_ready;
    end
  end

  // ---------------- driver tasks for dut_a ----------------
  task automatic a_read(input int id, input logic [7:0] addr, input bit chk_grant, input string tag);
    int k, hi;
    a_rd_addr[id*AB +: AB] = addr;
    a_rd_valid[id] = 1'b1;
    if (chk_grant) begin
      @(negedge clk);
      check({tag, "_grant"}, {a_mrv, a_mra}, {1'b1, addr});
    end
    k = 0;
    while (!a_rd_ready[id] && k < BUDGET) begin @(negedge clk); k++; end
    if (!a_rd_ready[id]) begin
      total++;
      $display("FAIL %s_timeout: no read ready after %0d cycles, expected ready", tag, BUDGET);
      a_rd_valid[id] = 1'b0;
      return;
    end
    hi = 0;
    while (a_rd_ready[id] && hi < 10) begin
      hi++;
      if (hi == 2) a_rd_valid[id] = 1'b0;
      @(negedge clk);
    end
    a_rd_valid[id] = 1'b0;
    check({tag, "_ready_cycles"}, hi, 2);
  endtask

  task automatic a_write(input int id, input logic [7:0] addr, input logic [7:0] data,
                         input bit chk_grant, input string tag);
    int k, hi;
    a_wr_addr[id*AB +: AB] = addr;
    a_wr_data[id*DB +: DB] = data;
    a_wr_valid[id] = 1'b1;
    if (chk_grant) begin
      @(negedge clk);
      check({tag, "_grant"}, {a_mwv, a_mwa, a_mwd}, {1'b1, addr, data});
    end
    k = 0;
    while (!a_wr_ready[id] && k < BUDGET) begin @(negedge clk); k++; end
    if (!a_wr_ready[id]) begin
      total++;
      $display("FAIL %s_timeout: no write ready after %0d cycles, expected ready", tag, BUDGET);
      a_wr_valid[id] = 1'b0;
      return;
    end
    hi = 0;
    while (a_wr_ready[id] && hi < 10) begin
      hi++;
      if (hi == 2) a_wr_valid[id] = 1'b0;
      @(negedge clk);
    end
    a_wr_valid[id] = 1'b0;
    check({tag, "_ready_cycles"}, hi, 2);
    check({tag, "_mem"}, mem_a[addr], data);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_wr;
    int          id;
    logic [7:0]  addr;
    logic [7:0]  data;   // write data, or expected read data
  } vec_t;

  vec_t vecs [8];

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bit bad;
    a_rd_valid = '0; a_rd_addr = '0; a_wr_valid = '0; a_wr_addr = '0; a_wr_data = '0;
    b_rd_valid = '0; b_rd_addr = '0; b_wr_valid = '0; b_wr_addr = '0; b_wr_data = '0;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'(i) ^ 8'h5A;
    mem_a[8'h3C] = 8'hA5;

    vecs[0] = '{1'b1, 0, 8'h10, 8'h7E};
    vecs[1] = '{1'b0, 0, 8'h10, 8'h7E};
    vecs[2] = '{1'b1, 3, 8'hFF, 8'h01};
    vecs[3] = '{1'b0, 1, 8'hFF, 8'h01};
    vecs[4] = '{1'b0, 3, 8'h00, 8'h5A};
    vecs[5] = '{1'b0, 2, 8'h81, 8'hDB};
    vecs[6] = '{1'b1, 2, 8'h81, 8'hC3};
    vecs[7] = '{1'b0, 1, 8'h81, 8'hC3};

    repeat (3) @(negedge clk);
    check("reset_outs_a", {a_rd_ready, a_rd_data, a_wr_ready, a_mrv, a_mra, a_mwv, a_mwa, a_mwd}, '0);
    reset = 1'b1;
    @(negedge clk);

    // Single read: consumer 2, address 0x3C, memory holds 0xA5.
    exp_q.push_back({2'd2, 8'hA5});
    a_read(2, 8'h3C, 1'b1, "single");
    check("single_others", {a_rd_data, a_rd_ready, a_wr_ready}, {32'h00A5_0000, 8'h00});

    // Table of reads and writes through the single channel.
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].is_wr) begin
        a_write(vecs[v].id, vecs[v].addr, vecs[v].data, 1'b1, $sformatf("vec%0d_wr", v));
      end else begin
        exp_q.push_back({2'(vecs[v].id), vecs[v].data});
        a_read(vecs[v].id, vecs[v].addr, 1'b1, $sformatf("vec%0d_rd", v));
      end
    end

    // Contention: all four read at once, served 0,1,2,3.
    exp_q.push_back({2'd0, 8'h7A});
    exp_q.push_back({2'd1, 8'h7B});
    exp_q.push_back({2'd2, 8'h78});
    exp_q.push_back({2'd3, 8'h79});
    fork
      a_read(0, 8'h20, 1'b0, "cont0");
      a_read(1, 8'h21, 1'b0, "cont1");
      a_read(2, 8'h22, 1'b0, "cont2");
      a_read(3, 8'h23, 1'b0, "cont3");
    join
    check("cont_drained", exp_q.size(), 0);

    // Read and write both valid on consumer 1: read goes first.
    exp_q.push_back({2'd1, 8'h1E});
    a_wr_addr[15:8] = 8'h45; a_wr_data[15:8] = 8'h99; a_wr_valid[1] = 1'b1;
    a_rd_addr[15:8] = 8'h44; a_rd_valid[1] = 1'b1;
    @(negedge clk);
    check("both_read_first", {a_mrv, a_mwv, a_mra}, {1'b1, 1'b0, 8'h44});
    bad = 1'b0; k = 0;
    while (!a_rd_ready[1] && k < BUDGET) begin @(negedge clk); if (a_mwv[0]) bad = 1'b1; k++; end
    check("both_rd_done", a_rd_ready[1], 1'b1);
    @(negedge clk); if (a_mwv[0]) bad = 1'b1;
    a_rd_valid[1] = 1'b0;
    @(negedge clk); if (a_mwv[0]) bad = 1'b1;
    check("both_wr_not_early", bad, 1'b0);
    a_write(1, 8'h45, 8'h99, 1'b1, "both_wr");

    // Reset in READ_WAIT with mem_read_valid high.
    mem_auto = 1'b0;
    @(negedge clk);
    a_rd_addr[7:0] = 8'h66; a_rd_valid[0] = 1'b1;
    @(negedge clk);
    check("rst_pre_wait", {a_mrv, a_mra}, {1'b1, 8'h66});
    reset = 1'b0;
    a_rd_valid[0] = 1'b0;
    @(negedge clk);
    check("rst_outs_a", {a_rd_ready, a_rd_data, a_wr_ready, a_mrv, a_mra, a_mwv, a_mwa, a_mwd}, '0);
    check("rst_outs_b", {b_rd_ready, b_rd_data, b_wr_ready, b_mrv, b_mra, b_mwv, b_mwa, b_mwd}, '0);
    reset = 1'b1;
    @(negedge clk);
    manual_rd_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) manual_rd_ready = 1'b0;
      if ((|a_rd_ready) || a_mrv[0]) bad = 1'b1;
    end
    check("rst_late_ready_ignored", bad, 1'b0);
    mem_auto = 1'b1;
    @(negedge clk);

    // Two channels: consumers 1 and 3 granted in the same cycle.
    b_rd_addr[15:8] = 8'h11; b_rd_addr[31:24] = 8'h33;
    b_rd_valid = 4'b1010;
    @(negedge clk);
    check("two_ch_grant", {b_mrv, b_mra}, {2'b11, 8'h33, 8'h11});
    k = 0;
    while (b_rd_ready != 4'b1010 && k < BUDGET) begin @(negedge clk); k++; end
    check("two_ch_done", {b_rd_ready, b_rd_data}, {4'b1010, 8'h69, 8'h00, 8'h4B, 8'h00});
    @(negedge clk);
    b_rd_valid = '0;
    repeat (2) @(negedge clk);
    check("two_ch_release", {b_rd_ready, b_mrv}, '0);

    // Read-only build: a write request never reaches memory.
    b_wr_addr[7:0] = 8'h10; b_wr_data[7:0] = 8'h7E; b_wr_valid[0] = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((|b_mwv) || (|b_wr_ready) || (|b_mrv)) bad = 1'b1;
    end
    check("ro_no_write", bad, 1'b0);
    b_wr_valid = '0;

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("no_channel_reuse", reuse_err, 0);
    check("no_overlap", overlap_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
